// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 4-bit CPU control unit.
// Holds the instruction field positions, opcode values, the ALU operation
// encoding and the control FSM state type.
package cpu_pkg;

    localparam int unsigned INSTR_W  = 8;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned RADDR_W  = 2;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned ALU_OP_W = 3;

    // Instruction byte layout: [7:4] op, [3:2] rd, [1:0] rs
    localparam int unsigned IR_OP_MSB = 7;
    localparam int unsigned IR_OP_LSB = 4;
    localparam int unsigned IR_RD_MSB = 3;
    localparam int unsigned IR_RD_LSB = 2;
    localparam int unsigned IR_RS_MSB = 1;
    localparam int unsigned IR_RS_LSB = 0;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_OR   = 4'h5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h7;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ   = 4'hA;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    // ALU operation code is the low three opcode bits (IR[6:4])
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_NONE = 3'd0,
        ALU_MOV  = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_SUB  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_NOT  = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_FETCH2 = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode: combinational opcode decoder.
// Ports:
//   op          in  4  opcode nibble IR[7:4]
//   is_two_byte out 1  instruction carries an immediate byte (LDI/JMP/JZ)
//   writes_rf   out 1  instruction writes the register file (ops 1..8)
//   is_alu      out 1  write data comes from the external ALU (ops 2..7)
//   is_jump     out 1  unconditional jump
//   is_jz       out 1  jump if zero flag set
//   is_halt     out 1  halt instruction
//   alu_op      out 3  ALU operation = IR[6:4]
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0]     op,
    output logic                is_two_byte,
    output logic                writes_rf,
    output logic                is_alu,
    output logic                is_jump,
    output logic                is_jz,
    output logic                is_halt,
    output logic [ALU_OP_W-1:0] alu_op
);

    // Opcode classification; B..E and NOP fall through with everything low
    always_comb begin
        is_two_byte = 1'b0;
        writes_rf   = 1'b0;
        is_alu      = 1'b0;
        is_jump     = 1'b0;
        is_jz       = 1'b0;
        is_halt     = 1'b0;
        alu_op      = op[ALU_OP_W-1:0];
        case (op)
            OP_MOV: writes_rf = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                writes_rf = 1'b1;
                is_alu    = 1'b1;
            end
            OP_LDI: begin
                writes_rf   = 1'b1;
                is_two_byte = 1'b1;
            end
            OP_JMP: begin
                is_two_byte = 1'b1;
                is_jump     = 1'b1;
            end
            OP_JZ: begin
                is_two_byte = 1'b1;
                is_jz       = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// cpu_control: multi-cycle control unit of the 4-bit CPU.
// Fetches instruction bytes, decodes them, and drives the 4x4 register file
// and external ALU. Holds PC, IR, immediate byte and zero flag.
// Build option: CPU_STEP_EN adds the step port; each step pulse sampled in
// S_FETCH releases exactly one instruction fetch.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   imem_req/imem_addr         fetch request and address (= pc)
//   imem_valid/imem_data       fetch response
//   rf_r_addr_a/rf_r_addr_b    rs / rd read addresses from IR
//   rf_r_data_a/rf_r_data_b    rs / rd read data
//   alu_op/alu_result          external ALU operation and result
//   rf_we/rf_w_addr/rf_w_data  one-cycle register-file write
//   pc, halted                 program counter, halt indicator
//   step                       single-step pulse (CPU_STEP_EN only)
module cpu_control
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_W     = 8,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [PC_W-1:0]         imem_addr,
    input  logic                    imem_valid,
    input  logic [INSTR_W-1:0]      imem_data,
    output logic [RADDR_W-1:0]      rf_r_addr_a,
    output logic [RADDR_W-1:0]      rf_r_addr_b,
    input  logic [DATA_W-1:0]       rf_r_data_a,
    input  logic [DATA_W-1:0]       rf_r_data_b,
    output logic [ALU_OP_W-1:0]     alu_op,
    input  logic [DATA_W-1:0]       alu_result,
    output logic                    rf_we,
    output logic [RADDR_W-1:0]      rf_w_addr,
    output logic [DATA_W-1:0]       rf_w_data,
    output logic [PC_W-1:0]         pc,
`ifdef CPU_STEP_EN
    input  logic                    step,
`endif
    output logic                    halted
);

    state_t               state;
    logic [INSTR_W-1:0]   ir;
    logic [INSTR_W-1:0]   imm;
    logic                 z;

    logic                 is_two_byte;
    logic                 writes_rf;
    logic                 is_alu;
    logic                 is_jump;
    logic                 is_jz;
    logic                 is_halt;
    logic [RADDR_W-1:0]   rd;

    // rd contents feed the external ALU directly; not needed here
    logic                 unused_rd_data;
    assign unused_rd_data = ^rf_r_data_b;

    assign rd          = ir[IR_RD_MSB:IR_RD_LSB];
    assign rf_r_addr_a = ir[IR_RS_MSB:IR_RS_LSB];
    assign rf_r_addr_b = rd;
    assign imem_addr   = pc;

    cpu_decode u_decode (
        .op          (ir[IR_OP_MSB:IR_OP_LSB]),
        .is_two_byte (is_two_byte),
        .writes_rf   (writes_rf),
        .is_alu      (is_alu),
        .is_jump     (is_jump),
        .is_jz       (is_jz),
        .is_halt     (is_halt),
        .alu_op      (alu_op)
    );

    // Control FSM with registered request/write outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            imm       <= '0;
            z         <= 1'b0;
            imem_req  <= 1'b0;
            rf_we     <= 1'b0;
            rf_w_addr <= '0;
            rf_w_data <= '0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
`ifdef CPU_STEP_EN
                    imem_req <= 1'b0;
`else
                    imem_req <= 1'b1;
`endif
                end
                S_FETCH: begin
                    if (imem_req && imem_valid) begin
                        ir       <= imem_data;
                        pc       <= pc + PC_W'(1);
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
`ifdef CPU_STEP_EN
                    // Step only releases a request that is not yet raised
                    else if (!imem_req && step) begin
                        imem_req <= 1'b1;
                    end
`endif
                end
                S_DECODE: begin
                    if (is_two_byte) begin
                        imem_req <= 1'b1;
                        state    <= S_FETCH2;
                    end else begin
                        // rf read data and ALU result are stable once IR is loaded
                        rf_we     <= writes_rf;
                        rf_w_addr <= rd;
                        rf_w_data <= is_alu ? alu_result : rf_r_data_a;
                        state     <= S_EXEC;
                    end
                end
                S_FETCH2: begin
                    if (imem_req && imem_valid) begin
                        imm      <= imem_data;
                        pc       <= pc + PC_W'(1);
                        imem_req <= 1'b0;
                        rf_we    <= writes_rf;
                        if (writes_rf) begin
                            rf_w_addr <= rd;
                            rf_w_data <= imem_data[DATA_W-1:0];
                        end
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rf_we <= 1'b0;
                    if (rf_we) begin
                        z <= (rf_w_data == '0);
                    end
                    if (is_jump || (is_jz && z)) begin
                        pc <= PC_W'(imm);
                    end
                    if (is_halt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
`ifdef CPU_STEP_EN
                        imem_req <= 1'b0;
`else
                        imem_req <= 1'b1;
`endif
                        state <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: scoreboard bench for cpu_control.
// Expected register writes and fetch addresses are queued with the stimulus;
// a forked monitor pops and compares them whenever the DUT presents a write
// or an accepted fetch. A second instance (PC_W=4) covers PC wraparound.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset4;
    logic        stall;

    always #5 clk = ~clk;

    // Main DUT (PC_W = 8)
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [7:0]  imem_data;
    logic [1:0]  rf_r_addr_a;
    logic [1:0]  rf_r_addr_b;
    logic [3:0]  rf_r_data_a;
    logic [3:0]  rf_r_data_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_result;
    logic        rf_we;
    logic [1:0]  rf_w_addr;
    logic [3:0]  rf_w_data;
    logic [7:0]  pc;
    logic        halted;
`ifdef CPU_STEP_EN
    logic        step;
`endif

    // Wrap DUT (PC_W = 4)
    logic        imem_req4;
    logic [3:0]  imem_addr4;
    logic [7:0]  imem_data4;
    logic        rf_we4;
    logic [3:0]  pc4;
    logic        halted4;
    logic [1:0]  d4_unused_ra;
    logic [1:0]  d4_unused_rb;
    logic [2:0]  d4_unused_op;
    logic [1:0]  d4_unused_wa;
    logic [3:0]  d4_unused_wd;

    logic [7:0]  mem  [256];
    logic [7:0]  mem4 [16];
    logic [3:0]  regs [4];

    logic [5:0]  exp_wr[$];
    logic [7:0]  exp_f[$];
    logic [3:0]  exp_f4[$];

    int checks = 0;
    int errors = 0;

    // Environment: zero-wait memory (stallable), register file and ALU
    assign imem_valid  = imem_req & ~stall;
    assign imem_data   = mem[imem_addr];
    assign imem_data4  = mem4[imem_addr4];
    assign rf_r_data_a = regs[rf_r_addr_a];
    assign rf_r_data_b = regs[rf_r_addr_b];

    function automatic logic [3:0] alu_model(input logic [2:0] op, input logic [3:0] d,
                                             input logic [3:0] s);
        case (op)
            3'd1:    return s;
            3'd2:    return d + s;
            3'd3:    return d - s;
            3'd4:    return d & s;
            3'd5:    return d | s;
            3'd6:    return d ^ s;
            3'd7:    return ~s;
            default: return 4'h0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_op, rf_r_data_b, rf_r_data_a);

    always @(posedge clk) begin
        if (rf_we) regs[rf_w_addr] <= rf_w_data;
    end

    cpu_control #(.PC_W(8), .RESET_PC(8'h00)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .rf_r_addr_a (rf_r_addr_a),
        .rf_r_addr_b (rf_r_addr_b),
        .rf_r_data_a (rf_r_data_a),
        .rf_r_data_b (rf_r_data_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_w_addr   (rf_w_addr),
        .rf_w_data   (rf_w_data),
        .pc          (pc),
`ifdef CPU_STEP_EN
        .step        (step),
`endif
        .halted      (halted)
    );

    cpu_control #(.PC_W(4), .RESET_PC(4'hD)) u_dut4 (
        .clk         (clk),
        .reset       (reset4),
        .imem_req    (imem_req4),
        .imem_addr   (imem_addr4),
        .imem_valid  (imem_req4),
        .imem_data   (imem_data4),
        .rf_r_addr_a (d4_unused_ra),
        .rf_r_addr_b (d4_unused_rb),
        .rf_r_data_a (4'h0),
        .rf_r_data_b (4'h0),
        .alu_op      (d4_unused_op),
        .alu_result  (4'h0),
        .rf_we       (rf_we4),
        .rf_w_addr   (d4_unused_wa),
        .rf_w_data   (d4_unused_wd),
        .pc          (pc4),
`ifdef CPU_STEP_EN
        .step        (1'b1),
`endif
        .halted      (halted4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Scoreboard monitor: samples on the falling edge
    task automatic monitor();
        logic [5:0] ew;
        logic [7:0] ef;
        logic [3:0] ef4;
        forever begin
            @(negedge clk);
            if (rf_we) begin
                if (exp_wr.size() == 0) unexpected("rf_write", 32'({rf_w_addr, rf_w_data}));
                else begin
                    ew = exp_wr.pop_front();
                    chk("rf_write", 32'({rf_w_addr, rf_w_data}), 32'(ew));
                end
            end
            if (imem_req && imem_valid) begin
                if (exp_f.size() == 0) unexpected("fetch_addr", 32'(imem_addr));
                else begin
                    ef = exp_f.pop_front();
                    chk("fetch_addr", 32'(imem_addr), 32'(ef));
                end
            end
            if (imem_req4) begin
                if (exp_f4.size() == 0) unexpected("fetch_addr4", 32'(imem_addr4));
                else begin
                    ef4 = exp_f4.pop_front();
                    chk("fetch_addr4", 32'(imem_addr4), 32'(ef4));
                end
            end
            if (rf_we4) unexpected("rf_we4", 32'(rf_we4));
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // LDI r1,5 ; LDI r2,3 ; ADD r2,r1 ; JZ 0x20 (Z=0, falls through) ; HALT
    task automatic load_prog1();
        clear_mem();
        mem[0] = 8'h84; mem[1] = 8'h05;
        mem[2] = 8'h88; mem[3] = 8'h03;
        mem[4] = 8'h29;
        mem[5] = 8'hA0; mem[6] = 8'h20;
        mem[7] = 8'hF0;
    endtask

    task automatic expect_prog1();
        exp_wr.push_back({2'd1, 4'h5});
        exp_wr.push_back({2'd2, 4'h3});
        exp_wr.push_back({2'd2, 4'h8});
        for (int i = 0; i < 8; i++) exp_f.push_back(8'(i));
    endtask

    task automatic wait_halt(input string name, input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        chk(name, 32'(halted), 32'd1);
    endtask

    task automatic drain_checks(input string name);
        chk({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        chk({name, "_fetch_left"}, 32'(exp_f.size()), 32'd0);
    endtask

    task automatic start_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        reset4 = 1'b1;
        stall  = 1'b0;
`ifdef CPU_STEP_EN
        step   = 1'b1;
`endif
        for (int i = 0; i < 4; i++) regs[i] = 4'h0;
        for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
        // JMP 0x0F at 0xD, NOP at 0xF, HALT at 0x0
        mem4[13] = 8'h90; mem4[14] = 8'h0F; mem4[15] = 8'h00; mem4[0] = 8'hF0;
        load_prog1();
        @(negedge clk);
        @(negedge clk);

        chk("rst_imem_req",  32'(imem_req),  32'd0);
        chk("rst_rf_we",     32'(rf_we),     32'd0);
        chk("rst_rf_w_addr", 32'(rf_w_addr), 32'd0);
        chk("rst_rf_w_data", 32'(rf_w_data), 32'd0);
        chk("rst_alu_op",    32'(alu_op),    32'd0);
        chk("rst_halted",    32'(halted),    32'd0);
        chk("rst_pc",        32'(pc),        32'd0);
        chk("rst_pc4",       32'(pc4),       32'hD);

        fork
            monitor();
        join_none

        // Wrap instance runs alongside the main tests
        exp_f4.push_back(4'hD);
        exp_f4.push_back(4'hE);
        exp_f4.push_back(4'hF);
        exp_f4.push_back(4'h0);
        reset4 = 1'b0;

        // Program 1: LDI/LDI/ADD, JZ not taken
        expect_prog1();
        reset = 1'b0;
        wait_halt("p1_halt", 200);
        drain_checks("p1");
        chk("p1_pc", 32'(pc), 32'h8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("p1_halt_req", 32'(imem_req), 32'd0);
            chk("p1_halt_hold", 32'(halted), 32'd1);
        end

        // Program 2: SUB to zero, JZ taken, NOT, JZ not taken, MOV, undefined op
        start_reset();
        clear_mem();
        mem[8'h00] = 8'h80; mem[8'h01] = 8'h07;
        mem[8'h02] = 8'h30;
        mem[8'h03] = 8'hA0; mem[8'h04] = 8'h10;
        mem[8'h10] = 8'h7C;
        mem[8'h11] = 8'hA0; mem[8'h12] = 8'h30;
        mem[8'h13] = 8'h17;
        mem[8'h14] = 8'hC0;
        mem[8'h15] = 8'hF0;
        exp_wr.push_back({2'd0, 4'h7});
        exp_wr.push_back({2'd0, 4'h0});
        exp_wr.push_back({2'd3, 4'hF});
        exp_wr.push_back({2'd1, 4'hF});
        for (int i = 0; i < 5; i++) exp_f.push_back(8'(i));
        for (int i = 16; i < 22; i++) exp_f.push_back(8'(i));
        reset = 1'b0;
        wait_halt("p2_halt", 200);
        drain_checks("p2");
        chk("p2_pc", 32'(pc), 32'h16);

        // Program 3: wait states on the first fetch
        start_reset();
        clear_mem();
        mem[0] = 8'h8C; mem[1] = 8'h09; mem[2] = 8'hF0;
        stall = 1'b1;
        exp_wr.push_back({2'd3, 4'h9});
        for (int i = 0; i < 3; i++) exp_f.push_back(8'(i));
        reset = 1'b0;
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_req",  32'(imem_req),  32'd1);
            chk("stall_addr", 32'(imem_addr), 32'd0);
            chk("stall_pc",   32'(pc),        32'd0);
            chk("stall_we",   32'(rf_we),     32'd0);
        end
        @(posedge clk);
        #1 stall = 1'b0;
        wait_halt("p3_halt", 200);
        drain_checks("p3");
        chk("p3_pc", 32'(pc), 32'h3);

        // Reset while stalled in the immediate fetch of the first LDI
        start_reset();
        load_prog1();
        exp_f.push_back(8'h00);
        reset = 1'b0;
        for (int i = 0; i < 20 && !(imem_req && imem_addr == 8'h00); i++) @(negedge clk);
        @(posedge clk);
        #1 stall = 1'b1;
        for (int i = 0; i < 20 && !(imem_req && imem_addr == 8'h01); i++) @(negedge clk);
        chk("f2_reached", 32'(imem_req && imem_addr == 8'h01), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("f2rst_imem_req",  32'(imem_req),  32'd0);
        chk("f2rst_rf_we",     32'(rf_we),     32'd0);
        chk("f2rst_rf_w_addr", 32'(rf_w_addr), 32'd0);
        chk("f2rst_rf_w_data", 32'(rf_w_data), 32'd0);
        chk("f2rst_alu_op",    32'(alu_op),    32'd0);
        chk("f2rst_halted",    32'(halted),    32'd0);
        chk("f2rst_pc",        32'(pc),        32'd0);
        chk("f2rst_wr_left",   32'(exp_wr.size()), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_prog1();
        reset = 1'b0;
        wait_halt("p4_halt", 200);
        drain_checks("p4");

        // Wrap instance results
        chk("wrap_halted", 32'(halted4), 32'd1);
        chk("wrap_pc", 32'(pc4), 32'h1);
        chk("wrap_fetch_left", 32'(exp_f4.size()), 32'd0);

`ifdef CPU_STEP_EN
        // Single-step: nothing without a pulse, one instruction per pulse
        start_reset();
        clear_mem();
        mem[0] = 8'h8C; mem[1] = 8'h09; mem[2] = 8'hF0;
        step = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("step_idle_req", 32'(imem_req), 32'd0);
        end
        exp_wr.push_back({2'd3, 4'h9});
        exp_f.push_back(8'h00);
        exp_f.push_back(8'h01);
        @(posedge clk);
        #1 step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (12) @(negedge clk);
        chk("step_pc", 32'(pc), 32'h2);
        chk("step_req", 32'(imem_req), 32'd0);
        drain_checks("step");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
